// File: rtl/cordic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cordic_pkg
// Brief    : Shared CORDIC constants: atan table, quadrants, gain, FSM codes.
// Revision : 1.0
// ---------------------------------------------------------------------------
package cordic_pkg;

  localparam int ANGLE_W      = 16;
  localparam int ATAN_ENTRIES = 14;

  // Q2.14 value of the 14-stage CORDIC gain, for downstream compensation
  localparam logic [15:0] CORDIC_GAIN = 16'd26980;

  localparam logic [1:0] QUAD_Q1 = 2'b00;
  localparam logic [1:0] QUAD_Q2 = 2'b01;
  localparam logic [1:0] QUAD_Q3 = 2'b10;
  localparam logic [1:0] QUAD_Q4 = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ITER = 1'b1;

  function automatic logic [ANGLE_W-1:0] atan_lut(input logic [3:0] idx);
    logic [ANGLE_W-1:0] val;
    case (idx)
      4'd0:    val = 16'd8192;
      4'd1:    val = 16'd4836;
      4'd2:    val = 16'd2555;
      4'd3:    val = 16'd1297;
      4'd4:    val = 16'd651;
      4'd5:    val = 16'd326;
      4'd6:    val = 16'd163;
      4'd7:    val = 16'd81;
      4'd8:    val = 16'd41;
      4'd9:    val = 16'd20;
      4'd10:   val = 16'd10;
      4'd11:   val = 16'd5;
      4'd12:   val = 16'd3;
      4'd13:   val = 16'd1;
      default: val = 16'd0;
    endcase
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_vec_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cordic_vec_stage
// Brief    : Combinational vectoring micro-rotation driving y toward zero.
// Revision : 1.0
// ---------------------------------------------------------------------------
module cordic_vec_stage #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic        [W-1:0] z_i,
  input  logic        [3:0]   shift_i,
  input  logic        [W-1:0] atan_i,
  output logic signed [W-1:0] x_o,
  output logic signed [W-1:0] y_o,
  output logic        [W-1:0] z_o
);

  logic signed [W-1:0] xs;
  logic signed [W-1:0] ys;

  assign xs = x_i >>> shift_i;
  assign ys = y_i >>> shift_i;

  always_comb begin
    x_o = x_i;
    y_o = y_i;
    z_o = z_i;
    if (y_i[W-1]) begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + atan_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_vectoring.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cordic_vectoring
// Brief    : Iterative CORDIC vectoring: (X,Y) -> gain-scaled magnitude, phase.
// Revision : 1.0
// ---------------------------------------------------------------------------
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 14,
  parameter int IN_W       = 14,
  parameter int Z_W        = ANGLE_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IN_W-1:0] X_in,
  input  logic [IN_W-1:0] Y_in,
  output logic            busy,
  output logic            done,
  output logic [Z_W-1:0]  mag_out,
  output logic [Z_W-1:0]  Z_out,
  output logic [1:0]      quart_out
);

  localparam int            CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERATIONS - 1);

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      iter_q;
  logic signed [Z_W-1:0] x_q, y_q;
  logic [Z_W-1:0]        z_q;
  logic                  zero_q;
  logic                  done_q;
  logic [Z_W-1:0]        mag_q, zout_q;

  logic signed [Z_W-1:0] x_ext, y_ext, x_step, y_step;
  logic [Z_W-1:0]        z_step, atan_val;
  logic                  accept, last_iter;

  assign x_ext     = {{(Z_W-IN_W){X_in[IN_W-1]}}, X_in};
  assign y_ext     = {{(Z_W-IN_W){Y_in[IN_W-1]}}, Y_in};
  assign accept    = (state_q == ST_IDLE) && start;
  assign last_iter = (iter_q == LAST);
  assign atan_val  = Z_W'(atan_lut(iter_q));

  cordic_vec_stage #(.W(Z_W)) u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (iter_q),
    .atan_i  (atan_val),
    .x_o     (x_step),
    .y_o     (y_step),
    .z_o     (z_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)     state_d = ST_ITER;
      ST_ITER: if (last_iter) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_ITER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
      mag_q  <= '0;
      zout_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        iter_q <= '0;
        zero_q <= (X_in == '0) && (Y_in == '0);
        // Left half-plane: rotate by 180 deg so the micro-rotations converge
        if (X_in[IN_W-1]) begin
          x_q <= -x_ext;
          y_q <= -y_ext;
          z_q <= {1'b1, {(Z_W-1){1'b0}}};
        end else begin
          x_q <= x_ext;
          y_q <= y_ext;
          z_q <= '0;
        end
      end else if (state_q == ST_ITER) begin
        x_q    <= x_step;
        y_q    <= y_step;
        z_q    <= z_step;
        iter_q <= iter_q + 1'b1;
        if (last_iter) begin
          done_q <= 1'b1;
          mag_q  <= zero_q ? '0 : $unsigned(x_step);
          zout_q <= zero_q ? '0 : z_step;
        end
      end
    end
  end

  assign done      = done_q;
  assign mag_out   = mag_q;
  assign Z_out     = zout_q;
  assign quart_out = zout_q[Z_W-1 -: 2];

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_cordic_vectoring
// Brief    : Scoreboard bench for cordic_vectoring against an integer model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_cordic_vectoring;

  localparam int    ITER = 14;
  localparam real   PI   = 3.14159265358979;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] X_in, Y_in;
  logic        busy, done;
  logic [15:0] mag_out, Z_out;
  logic [1:0]  quart_out;

  cordic_vectoring #(.ITERATIONS(ITER), .IN_W(14), .Z_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .X_in      (X_in),
    .Y_in      (Y_in),
    .busy      (busy),
    .done      (done),
    .mag_out   (mag_out),
    .Z_out     (Z_out),
    .quart_out (quart_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mag;
    int z;
    int quart;
    int done_cyc;
    int xin;
    int yin;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  real  gain;
  int   atan_t [14] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1};

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural vectoring with plain integers, straight from the algorithm rules
  function automatic void ref_model(input int X, input int Y, output int mag, output int z);
    int x, y, zz, xn, yn;
    if (X == 0 && Y == 0) begin
      mag = 0;
      z   = 0;
      return;
    end
    if (X < 0) begin x = -X; y = -Y; zz = 32768; end
    else       begin x = X;  y = Y;  zz = 0;     end
    for (int i = 0; i < ITER; i++) begin
      if (y >= 0) begin xn = x + (y >>> i); yn = y - (x >>> i); zz = zz + atan_t[i]; end
      else        begin xn = x - (y >>> i); yn = y + (x >>> i); zz = zz - atan_t[i]; end
      x = xn;
      y = yn;
    end
    mag = x;
    z   = zz & 32'hFFFF;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int expv, input int tol, input bit wrap);
    int d;
    d = act - expv;
    if (wrap) begin
      d = d & 32'hFFFF;
      if (d > 32767) d = d - 65536;
    end
    n_cmp++;
    if (d > tol || d < -tol) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d +/-%0d (cycle %0d)", name, act, expv, tol, cyc);
    end
  endtask

  task automatic issue(input int X, input int Y);
    exp_t e;
    ref_model(X, Y, e.mag, e.z);
    e.quart    = (e.z >> 14) & 3;
    e.done_cyc = cyc + ITER + 1;
    e.xin      = X;
    e.yin      = Y;
    X_in       = X[13:0];
    Y_in       = Y[13:0];
    start      = 1'b1;
    sb.push_back(e);
    last_exp   = e;
  endtask

  task automatic wait_drain(input int bound);
    for (int t = 0; t < bound && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d pending results required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 required no pending result (cycle %0d)", cyc);
      end else begin
        int  ax, ay, phi;
        real ph;
        mon_e = sb.pop_front();
        check("mag", int'(mag_out), mon_e.mag);
        check("phase", int'(Z_out), mon_e.z);
        check("quart", int'(quart_out), mon_e.quart);
        check("latency", cyc, mon_e.done_cyc);
        ax = (mon_e.xin < 0) ? -mon_e.xin : mon_e.xin;
        ay = (mon_e.yin < 0) ? -mon_e.yin : mon_e.yin;
        if (ax >= 1000 || ay >= 1000) begin
          ph = $atan2(real'(mon_e.yin), real'(mon_e.xin)) * 65536.0 / (2.0 * PI);
          if (ph < 0.0) ph = ph + 65536.0;
          phi = int'(ph);
          check_tol("ideal_phase", int'(Z_out), phi, 64, 1'b1);
          check_tol("ideal_mag", int'(mag_out),
                    int'(gain * $sqrt(real'(mon_e.xin) * mon_e.xin + real'(mon_e.yin) * mon_e.yin)),
                    32, 1'b0);
        end
      end
    end
  end

  int dx [10] = '{1000, 0, -1000, 1000, -8192, 0, -8192, 8191, 0, -1};
  int dy [10] = '{0, 1000, 0, -1000, -8192, 0, 0, 8191, -8192, 1};

  initial begin
    gain = 1.0;
    for (int i = 0; i < ITER; i++) gain = gain * $sqrt(1.0 + 1.0 / (4.0 ** i));

    reset = 1'b1;
    start = 1'b0;
    X_in  = '0;
    Y_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mag", int'(mag_out), 0);
    check("rst_z", int'(Z_out), 0);
    check("rst_quart", int'(quart_out), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      issue(dx[k], dy[k]);
      @(negedge clk);
      start = 1'b0;
      X_in  = 14'($urandom);
      Y_in  = 14'($urandom);
      check("busy_after_start", int'(busy), 1);
      wait_drain(40);
    end

    for (int k = 0; k < 40; k++) begin
      issue(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
      @(negedge clk);
      start = 1'b0;
      wait_drain(40);
    end

    // start held high: a new sample is taken on each done cycle
    for (int k = 0; k < 4; k++) begin
      issue(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
      repeat (ITER + 1) @(negedge clk);
    end
    start = 1'b0;
    wait_drain(40);

    issue(2500, 1800);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    X_in  = 14'(-3000);
    Y_in  = 14'(77);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);
    repeat (20) @(negedge clk);
    check("hold_mag", int'(mag_out), last_exp.mag);
    check("hold_z", int'(Z_out), last_exp.z);

    issue(3000, -2000);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_mag", int'(mag_out), 0);
    check("abort_z", int'(Z_out), 0);
    check("abort_quart", int'(quart_out), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    issue(-4000, 3000);
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
